// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, stall/redirect
// handling, saturating fetch/flush counters and a sticky misaligned-target flag.
module if_stage #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INST = 32'h0000_0013,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_if,
    input  logic             flush_if,
    input  logic [XLEN-1:0]  branch_target,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [XLEN-1:0]  if_id_pc4,
    output logic [31:0]      if_id_inst,
    output logic             if_id_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_pc;
    logic            target_misaligned;

    assign imem_addr         = pc;
    assign pc_plus4          = pc + XLEN'(4);
    assign redirect_pc       = {branch_target[XLEN-1:2], 2'b00};
    assign target_misaligned = (branch_target[1:0] != 2'b00);

    // PC and IF/ID register: reset > flush > stall > normal fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else if (flush_if) begin
            pc          <= redirect_pc;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else if (!stall_if) begin
            pc          <= pc_plus4;
            if_id_pc    <= pc;
            if_id_pc4   <= pc_plus4;
            if_id_inst  <= imem_rdata;
            if_id_valid <= 1'b1;
        end
    end

    // Performance counters saturate rather than wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush_if) begin
            if (flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end else if (!stall_if) begin
            if (fetch_cnt != CNT_MAX) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
        end
    end

    // Misaligned redirect flag stays set until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err <= 1'b0;
        end else if (flush_if && target_misaligned) begin
            misalign_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized stall/flush/reset
// traffic compared cycle by cycle against a behavioural fetch model.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall_if;
    logic        flush_if;
    logic [63:0] branch_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [63:0] if_id_pc;
    logic [63:0] if_id_pc4;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        misalign_err;
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;

    int n_pass;
    int n_total;

    // behavioural model state
    logic [63:0] m_pc;
    logic [63:0] m_ipc;
    logic [63:0] m_ipc4;
    logic [31:0] m_inst;
    logic        m_valid;
    logic        m_mis;
    longint unsigned m_fetch;
    longint unsigned m_flush;

    if_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall_if      (stall_if),
        .flush_if      (flush_if),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4),
        .if_id_inst    (if_id_inst),
        .if_id_valid   (if_id_valid),
        .misalign_err  (misalign_err),
        .fetch_cnt     (fetch_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory: word content derived from its address
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'h0010_0093 + a[31:0];
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // One clock: drive inputs, advance the model on the edge, settle after it
    task automatic cyc(input logic r, input logic s, input logic f, input logic [63:0] bt);
        reset         = r;
        stall_if      = s;
        flush_if      = f;
        branch_target = bt;
        @(posedge clk);
        if (r) begin
            m_pc = 64'h0; m_ipc = 64'h0; m_ipc4 = 64'h0; m_inst = 32'h13;
            m_valid = 1'b0; m_mis = 1'b0; m_fetch = 0; m_flush = 0;
        end else if (f) begin
            m_pc = (bt / 4) * 4;
            m_ipc = 64'h0; m_ipc4 = 64'h0; m_inst = 32'h13; m_valid = 1'b0;
            if (bt % 4 != 0) m_mis = 1'b1;
            if (m_flush < 64'hFFFF_FFFF) m_flush++;
        end else if (!s) begin
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 64'd4;
            m_inst  = mem_word(m_pc);
            m_valid = 1'b1;
            m_pc    = m_pc + 64'd4;
            if (m_fetch < 64'hFFFF_FFFF) m_fetch++;
        end
        #1;
        reset = 1'b0; stall_if = 1'b0; flush_if = 1'b0;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 64'h0);
        cyc(1, 1, 1, 64'h123);
        n_total++; if (imem_addr !== 64'h0) $display("FAIL reset_pc got=%h exp=0", imem_addr); else n_pass++;
        n_total++; if ({if_id_pc, if_id_pc4} !== 128'h0) $display("FAIL reset_ifid_pc got=%h/%h exp=0/0", if_id_pc, if_id_pc4); else n_pass++;
        n_total++; if (if_id_inst !== 32'h13 || if_id_valid !== 1'b0) $display("FAIL reset_ifid_inst got=%h v=%b exp=13 v=0", if_id_inst, if_id_valid); else n_pass++;
        n_total++; if (misalign_err !== 1'b0 || fetch_cnt !== 32'd0 || flush_cnt !== 32'd0) $display("FAIL reset_status got mis=%b fc=%0d flc=%0d exp 0/0/0", misalign_err, fetch_cnt, flush_cnt); else n_pass++;
    endtask

    task automatic test_fetch();
        cyc(1, 0, 0, 64'h0);
        cyc(1, 0, 0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 64'h0);
            n_total++;
            if (if_id_pc !== 64'(4 * i) || if_id_valid !== 1'b1 || if_id_inst !== 32'h0010_0093 + 32'(4 * i) || if_id_pc4 !== 64'(4 * i + 4))
                $display("FAIL fetch_%0d got pc=%h pc4=%h inst=%h v=%b exp pc=%h", i, if_id_pc, if_id_pc4, if_id_inst, if_id_valid, 64'(4 * i));
            else n_pass++;
        end
        n_total++; if (fetch_cnt !== 32'd4 || imem_addr !== 64'h10) $display("FAIL fetch_cnt got=%0d addr=%h exp 4/10", fetch_cnt, imem_addr); else n_pass++;
    endtask

    task automatic test_stall();
        cyc(1, 0, 0, 64'h0);
        cyc(0, 0, 0, 64'h0);
        cyc(0, 0, 0, 64'h0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 64'h0);
            n_total++;
            if (imem_addr !== 64'h8 || if_id_pc !== 64'h4 || fetch_cnt !== 32'd2 || if_id_valid !== 1'b1)
                $display("FAIL stall_%0d got addr=%h pc=%h fc=%0d exp 8/4/2", i, imem_addr, if_id_pc, fetch_cnt);
            else n_pass++;
        end
        cyc(0, 0, 0, 64'h0);
        n_total++; if (if_id_pc !== 64'h8 || fetch_cnt !== 32'd3) $display("FAIL stall_resume got pc=%h fc=%0d exp 8/3", if_id_pc, fetch_cnt); else n_pass++;
    endtask

    task automatic test_flush();
        cyc(1, 0, 0, 64'h0);
        cyc(0, 0, 0, 64'h0);
        cyc(0, 0, 1, 64'h40);
        n_total++;
        if (if_id_inst !== 32'h13 || if_id_valid !== 1'b0 || flush_cnt !== 32'd1 || imem_addr !== 64'h40 || if_id_pc !== 64'h0)
            $display("FAIL flush_bubble got inst=%h v=%b flc=%0d addr=%h exp 13/0/1/40", if_id_inst, if_id_valid, flush_cnt, imem_addr);
        else n_pass++;
        cyc(0, 0, 0, 64'h0);
        n_total++;
        if (if_id_pc !== 64'h40 || if_id_valid !== 1'b1 || if_id_inst !== 32'h0010_00D3 || fetch_cnt !== 32'd2)
            $display("FAIL flush_target got pc=%h v=%b inst=%h fc=%0d exp 40/1/001000d3/2", if_id_pc, if_id_valid, if_id_inst, fetch_cnt);
        else n_pass++;
    endtask

    task automatic test_flush_stall();
        cyc(1, 0, 0, 64'h0);
        cyc(0, 0, 0, 64'h0);
        cyc(0, 1, 1, 64'h80);
        n_total++;
        if (imem_addr !== 64'h80 || if_id_valid !== 1'b0 || if_id_inst !== 32'h13 || flush_cnt !== 32'd1)
            $display("FAIL flush_stall got addr=%h v=%b inst=%h flc=%0d exp 80/0/13/1", imem_addr, if_id_valid, if_id_inst, flush_cnt);
        else n_pass++;
    endtask

    task automatic test_misalign();
        cyc(1, 0, 0, 64'h0);
        cyc(0, 0, 1, 64'h42);
        n_total++; if (imem_addr !== 64'h40 || misalign_err !== 1'b1) $display("FAIL misalign_set got addr=%h mis=%b exp 40/1", imem_addr, misalign_err); else n_pass++;
        cyc(0, 0, 0, 64'h0);
        cyc(0, 0, 1, 64'h100);
        cyc(0, 0, 0, 64'h0);
        n_total++;
        if (misalign_err !== 1'b1 || if_id_pc !== 64'h100 || flush_cnt !== 32'd2)
            $display("FAIL misalign_sticky got mis=%b pc=%h flc=%0d exp 1/100/2", misalign_err, if_id_pc, flush_cnt);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        cyc(1, 0, 0, 64'h0);
        cyc(0, 0, 0, 64'h0);
        cyc(0, 0, 1, 64'h203);
        cyc(0, 0, 0, 64'h0);
        cyc(1, 0, 0, 64'h0);
        n_total++;
        if (imem_addr !== 64'h0 || if_id_pc !== 64'h0 || if_id_pc4 !== 64'h0 || if_id_inst !== 32'h13 || if_id_valid !== 1'b0 ||
            misalign_err !== 1'b0 || fetch_cnt !== 32'd0 || flush_cnt !== 32'd0)
            $display("FAIL mid_reset got addr=%h pc=%h inst=%h v=%b mis=%b fc=%0d flc=%0d exp all reset", imem_addr, if_id_pc, if_id_inst, if_id_valid, misalign_err, fetch_cnt, flush_cnt);
        else n_pass++;
        cyc(0, 0, 0, 64'h0);
        n_total++; if (if_id_pc !== 64'h0 || if_id_valid !== 1'b1 || fetch_cnt !== 32'd1) $display("FAIL first_valid got pc=%h v=%b fc=%0d exp 0/1/1", if_id_pc, if_id_valid, fetch_cnt); else n_pass++;
    endtask

    task automatic test_wrap();
        cyc(1, 0, 0, 64'h0);
        cyc(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(0, 0, 0, 64'h0);
        n_total++;
        if (imem_addr !== 64'h0 || if_id_pc4 !== 64'h0 || if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || if_id_inst !== 32'h0010_008F)
            $display("FAIL pc_wrap got addr=%h pc=%h pc4=%h inst=%h exp 0/fffffffffffffffc/0/0010008f", imem_addr, if_id_pc, if_id_pc4, if_id_inst);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] bt;
        logic r, s, f;
        cyc(1, 0, 0, 64'h0);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            f  = ($urandom_range(0, 99) < 15);
            s  = ($urandom_range(0, 99) < 25);
            bt = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            cyc(r, s, f, bt);
            n_total++;
            if (imem_addr !== m_pc || if_id_pc !== m_ipc || if_id_pc4 !== m_ipc4 || if_id_inst !== m_inst || if_id_valid !== m_valid ||
                misalign_err !== m_mis || fetch_cnt !== 32'(m_fetch) || flush_cnt !== 32'(m_flush))
                $display("FAIL random_%0d got addr=%h pc=%h pc4=%h inst=%h v=%b mis=%b fc=%0d flc=%0d exp addr=%h pc=%h pc4=%h inst=%h v=%b mis=%b fc=%0d flc=%0d",
                         i, imem_addr, if_id_pc, if_id_pc4, if_id_inst, if_id_valid, misalign_err, fetch_cnt, flush_cnt,
                         m_pc, m_ipc, m_ipc4, m_inst, m_valid, m_mis, m_fetch, m_flush);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1; stall_if = 1'b0; flush_if = 1'b0; branch_target = 64'h0;
        test_reset();
        test_fetch();
        test_stall();
        test_flush();
        test_flush_stall();
        test_misalign();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
